// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and flag bit positions for the
// execute stage and its sequential multiplier.
package alu_pkg;

  localparam int FLAG_W = 5;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_NOT   = 4'h5;
  localparam logic [3:0] OP_SHL   = 4'h6;
  localparam logic [3:0] OP_SHR   = 4'h7;
  localparam logic [3:0] OP_MUL   = 4'h8;
  localparam logic [3:0] OP_PASSB = 4'h9;

  localparam int FLG_Z   = 0;
  localparam int FLG_N   = 1;
  localparam int FLG_C   = 2;
  localparam int FLG_V   = 3;
  localparam int FLG_ILL = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [FLAG_W-1:0] pack_flags(input logic ill, input logic v,
                                                   input logic c, input logic n,
                                                   input logic z);
    logic [FLAG_W-1:0] f;
    f          = '0;
    f[FLG_ILL] = ill;
    f[FLG_V]   = v;
    f[FLG_C]   = c;
    f[FLG_N]   = n;
    f[FLG_Z]   = z;
    return f;
  endfunction

endpackage

// File: rtl/mul_seq16.sv
// Iterative shift-add multiplier: one partial product per clock, W clocks.
// done and product are combinational and describe the final iteration edge.
module mul_seq16 #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CNT_W = $clog2(W);

  logic [2*W-1:0] mcand;
  logic [2*W-1:0] acc;
  logic [W-1:0]   mplier;
  logic [CNT_W-1:0] cnt;
  logic           running;

  // Value the accumulator takes on this edge; on the last step it is the full product.
  assign product = acc + (mplier[0] ? mcand : '0);
  assign done    = running && (cnt == CNT_W'(W - 1));

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples values from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
    end else if (running) begin
      cnt <= cnt + 1'b1;
      if (done) running <= 1'b0;
    end
  end

  // NOTE: pure datapath registers carry no reset; they are reloaded on start
  // and only observed while running is set.
  always_ff @(posedge clk) begin
    if (start) begin
      mcand  <= {{W{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
    end else if (running) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute stage: single-cycle ALU ops plus an iterative MUL, with valid/ready
// handshakes on both sides so writeback can stall the stage.
module alu_exec
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   opcode,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [FLAG_W-1:0] flags,
  output logic              busy
);

  localparam int MSB = DATA_W - 1;

  state_t              state;
  logic                accept;
  logic                mul_start;
  logic                mul_done;
  logic [2*DATA_W-1:0] mul_product;

  logic [DATA_W-1:0]   alu_res;
  logic [FLAG_W-1:0]   alu_flags;
  logic [DATA_W:0]     sum_ext;
  logic [DATA_W:0]     diff_ext;
  logic [DATA_W:0]     shl_ext;
  logic [DATA_W:0]     shr_ext;
  logic [3:0]          shamt;
  logic                c_flag;
  logic                v_flag;
  logic                ill_flag;

  assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (opcode == OP_MUL);
  assign shamt     = opb[3:0];

  mul_seq16 #(.W(DATA_W)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (opa),
    .b       (opb),
    .done    (mul_done),
    .product (mul_product)
  );

  // One extra bit on each shift captures the last bit shifted out as carry.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    alu_res  = '0;
    c_flag   = 1'b0;
    v_flag   = 1'b0;
    ill_flag = 1'b0;
    sum_ext  = {1'b0, opa} + {1'b0, opb};
    diff_ext = {1'b0, opa} - {1'b0, opb};
    shl_ext  = {1'b0, opa} << shamt;
    shr_ext  = {opa, 1'b0} >> shamt;
    case (opcode)
      OP_ADD: begin
        alu_res = sum_ext[MSB:0];
        c_flag  = sum_ext[DATA_W];
        v_flag  = (opa[MSB] == opb[MSB]) && (alu_res[MSB] != opa[MSB]);
      end
      OP_SUB: begin
        alu_res = diff_ext[MSB:0];
        c_flag  = diff_ext[DATA_W];
        v_flag  = (opa[MSB] != opb[MSB]) && (alu_res[MSB] != opa[MSB]);
      end
      OP_AND:   alu_res = opa & opb;
      OP_OR:    alu_res = opa | opb;
      OP_XOR:   alu_res = opa ^ opb;
      OP_NOT:   alu_res = ~opa;
      OP_SHL: begin
        alu_res = shl_ext[MSB:0];
        c_flag  = shl_ext[DATA_W];
      end
      OP_SHR: begin
        alu_res = shr_ext[DATA_W:1];
        c_flag  = shr_ext[0];
      end
      OP_MUL:   alu_res = '0;
      OP_PASSB: alu_res = opb;
      default:  ill_flag = 1'b1;
    endcase
    alu_flags = pack_flags(ill_flag, v_flag, c_flag, alu_res[MSB], alu_res == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (opcode == OP_MUL) begin
              state     <= ST_MUL;
              busy      <= 1'b1;
              out_valid <= 1'b0;
            end else begin
              state     <= ST_DONE;
              result    <= alu_res;
              flags     <= alu_flags;
              out_valid <= 1'b1;
            end
          end else if ((state == ST_DONE) && out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state     <= ST_DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            result    <= mul_product[MSB:0];
            flags     <= pack_flags(1'b0, 1'b0, |mul_product[2*DATA_W-1:DATA_W],
                                    mul_product[MSB], mul_product[MSB:0] == '0);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
